decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Pipeline register between instruction fetch and execute. It accepts 16-bit instruction words with their PC through a valid/ready handshake. It splits each word into the 8-bit instructionOp, the 8-bit immediate, and the Rdest/Rsrc fields consumed by the sign-extend unit and the register file. It holds a two-entry skid buffer so fetch can run at full rate under execute backpressure, supports a branch flush, and counts issued instructions.

Parameters:
PC_WIDTH, 16, width of the program counter carried with each instruction
COUNT_WIDTH, 16, width of the issued-instruction counter

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  fetch presents a valid instruction
in_ready  output  1  stage can accept an instruction this cycle
instruction  input  16  raw instruction word [15:12]=op, [11:8]=Rdest/cond, [7:4]=ext/ImmHi, [3:0]=Rsrc/ImmLo
pc_in  input  PC_WIDTH  PC of the instruction
flush  input  1  branch/jump taken in execute; discard everything held and in flight
out_valid  output  1  decoded instruction available
out_ready  input  1  execute consumes the decoded instruction
instructionOp  output  8  decoded opcode for execute and sign extend
immediate  output  8  instruction[7:0]
rdest  output  4  instruction[11:8] (condition code for Bcond/Jcond)
rsrc  output  4  instruction[3:0]
pc_out  output  PC_WIDTH  PC of the presented instruction
issue_count  output  COUNT_WIDTH  number of completed out handshakes

Behaviour:
- Reset (reset low, asynchronous): out_valid=0, skid empty, instructionOp=0, immediate=0, rdest=0, rsrc=0, pc_out=0, issue_count=0. in_ready=1 in the first cycle after reset deasserts.
- Opcode rule (combinational on the incoming word, registered on capture):
  - op in {0000, 0100, 1000}: instructionOp = {op, ext}.
  - Otherwise: instructionOp = {op, 4'b0000}.
  - Examples: LSHI gives 1000_000s; BCOND gives 1100_0000.
- Storage: output register (OR) and skid register (SR), each holding decoded fields, PC and a valid bit.
- in_ready = !SR.valid. This is a registered-state function, not combinational on out_ready.
- Accept occurs when in_valid && in_ready. Issue occurs when out_valid && out_ready. out_valid = OR.valid.
- Per-cycle update when flush=0:
  - Issue and SR valid: OR <= SR, SR cleared. An accept in the same cycle goes to SR.
  - Issue, SR empty, accept: OR <= new word.
  - Issue, SR empty, no accept: OR.valid <= 0.
  - No issue, OR empty, accept: OR <= new word.
  - No issue, OR valid, accept: SR <= new word.
- Ordering: strictly FIFO, with SR never older than OR. Latency is one cycle from accept to out_valid when the stage is empty.
- Outputs hold stable while out_valid && !out_ready.
- Flush (priority over everything):
  - OR.valid and SR.valid are cleared next edge.
  - An accept in the flush cycle is discarded.
  - An issue in the flush cycle still counts, because execute already took it.
  - Data fields may keep stale values. Only the valid bits are cleared.
- issue_count increments by 1 on each issue and wraps from all-ones to 0.
- Reset asserted mid-operation drops all held instructions immediately. There is no partial state.

Test Plan:
- Decode 0x53FB (ADDI R3,#-5) with out_ready=1 -> next cycle out_valid=1, instructionOp=0x50, immediate=0xFB, rdest=3, rsrc=0xB; issue_count 0->1.
- Stream 0x0251 (ADD R2,R1), 0x841E (LSHI R4,#-2), 0xC1FE (BCOND) back-to-back -> instructionOp 0x05, 0x81, 0xC0 on consecutive cycles, in_ready constantly 1.
- Hold out_ready=0 while offering 3 words (PCs 0x10, 0x11, 0x12) -> first two captured, in_ready=0 from cycle 3, 0x12 held by fetch; raise out_ready -> PCs issue 0x10, 0x11, 0x12 in order, no loss or duplication.
- With OR and SR full, assert flush for one cycle with in_valid=1 and out_ready=0 -> out_valid=0 and in_ready=1 next cycle, issue_count unchanged, flushed-cycle word never appears.
- Preload issue_count to all-ones via 65535 issues (or a forced value), issue once more -> issue_count=0.
- Assert reset low between edges while out_valid=1 -> out_valid and all outputs 0 immediately, without waiting for clk; after release, a fresh word decodes normally.

Source files
------------

// File: rtl/decode_stage.sv
// Fetch-to-execute pipeline register: splits the instruction word into decoded fields
// and holds up to two instructions (output + skid) under execute backpressure.
module decode_stage #(
    parameter int PC_WIDTH    = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0]            instruction,
    input  logic [PC_WIDTH-1:0]    pc_in,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             instructionOp,
    output logic [7:0]             immediate,
    output logic [3:0]             rdest,
    output logic [3:0]             rsrc,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic [COUNT_WIDTH-1:0] issue_count
);

    typedef struct packed {
        logic [7:0]          op;
        logic [7:0]          imm;
        logic [3:0]          rdest;
        logic [3:0]          rsrc;
        logic [PC_WIDTH-1:0] pc;
    } entry_t;

    entry_t                 or_q, or_d, sr_q, sr_d, new_e;
    logic                   or_vld_q, or_vld_d, sr_vld_q, sr_vld_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   accept, issue;

    assign in_ready = !sr_vld_q;
    assign accept   = in_valid && in_ready;
    assign issue    = or_vld_q && out_ready;

    // Only the ALU-class groups (0000, 0100, 1000) carry a sub-opcode in [7:4].
    always_comb begin
        new_e       = '0;
        new_e.op    = {instruction[15:12], 4'b0000};
        if (instruction[15:12] == 4'b0000 || instruction[15:12] == 4'b0100 ||
            instruction[15:12] == 4'b1000)
            new_e.op = instruction[15:8] & 8'hF0 | {4'b0000, instruction[7:4]};
        new_e.imm   = instruction[7:0];
        new_e.rdest = instruction[11:8];
        new_e.rsrc  = instruction[3:0];
        new_e.pc    = pc_in;
    end

    always_comb begin
        or_d     = or_q;
        sr_d     = sr_q;
        or_vld_d = or_vld_q;
        sr_vld_d = sr_vld_q;
        cnt_d    = cnt_q + {{(COUNT_WIDTH-1){1'b0}}, issue};
        if (flush) begin
            // Data fields are left stale; only validity matters after a flush.
            or_vld_d = 1'b0;
            sr_vld_d = 1'b0;
        end else if (issue) begin
            if (sr_vld_q) begin
                or_d     = sr_q;
                or_vld_d = 1'b1;
                sr_vld_d = 1'b0;
                if (accept) begin
                    sr_d     = new_e;
                    sr_vld_d = 1'b1;
                end
            end else if (accept) begin
                or_d     = new_e;
                or_vld_d = 1'b1;
            end else begin
                or_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!or_vld_q) begin
                or_d     = new_e;
                or_vld_d = 1'b1;
            end else begin
                sr_d     = new_e;
                sr_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            or_q     <= '0;
            sr_q     <= '0;
            or_vld_q <= 1'b0;
            sr_vld_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            or_q     <= or_d;
            sr_q     <= sr_d;
            or_vld_q <= or_vld_d;
            sr_vld_q <= sr_vld_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid     = or_vld_q;
    assign instructionOp = or_q.op;
    assign immediate     = or_q.imm;
    assign rdest         = or_q.rdest;
    assign rsrc          = or_q.rsrc;
    assign pc_out        = or_q.pc;
    assign issue_count   = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, streaming, backpressure, flush, counter wrap, async reset.
module tb_decode_stage;

    logic        clk, reset;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [15:0] instruction, pc_in, pc_out, issue_count;
    logic [7:0]  instructionOp, immediate;
    logic [3:0]  rdest, rsrc;
    int          n_cmp, n_err;

    decode_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_in(pc_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .instructionOp(instructionOp),
        .immediate(immediate), .rdest(rdest), .rsrc(rsrc), .pc_out(pc_out),
        .issue_count(issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] ins, input logic [15:0] pc);
        in_valid    = 1'b1;
        instruction = ins;
        pc_in       = pc;
    endtask

    initial begin
        int k;
        n_cmp = 0; n_err = 0;
        in_valid = 0; instruction = 0; pc_in = 0; flush = 0; out_ready = 0;
        reset = 0;
        #12 reset = 1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_op", instructionOp, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_count", issue_count, 0);

        // single decode: ADDI R3,#-5
        offer(16'h53FB, 16'h0100); out_ready = 1;
        tick();
        in_valid = 0;
        chk("addi_valid", out_valid, 1);
        chk("addi_op", instructionOp, 8'h50);
        chk("addi_imm", immediate, 8'hFB);
        chk("addi_rdest", rdest, 4'h3);
        chk("addi_rsrc", rsrc, 4'hB);
        chk("addi_pc", pc_out, 16'h0100);
        chk("addi_cnt0", issue_count, 0);
        tick();
        chk("addi_cnt1", issue_count, 1);
        chk("addi_drained", out_valid, 0);

        // back-to-back stream
        offer(16'h0251, 16'h0200); tick();
        chk("s0_op", instructionOp, 8'h05);
        chk("s0_rdy", in_ready, 1);
        offer(16'h841E, 16'h0201); tick();
        chk("s1_op", instructionOp, 8'h81);
        chk("s1_rdy", in_ready, 1);
        offer(16'hC1FE, 16'h0202); tick();
        chk("s2_op", instructionOp, 8'hC0);
        chk("s2_rdy", in_ready, 1);
        chk("s2_valid", out_valid, 1);
        in_valid = 0; tick();
        chk("s_cnt", issue_count, 4);

        // backpressure: three words, only two captured
        out_ready = 0;
        offer(16'h1234, 16'h0010); tick();
        chk("bp_rdy1", in_ready, 1);
        offer(16'h1235, 16'h0011); tick();
        chk("bp_rdy2", in_ready, 0);
        offer(16'h1236, 16'h0012); tick();
        chk("bp_rdy3", in_ready, 0);
        chk("bp_hold_pc", pc_out, 16'h0010);
        out_ready = 1; tick();
        chk("bp_pc11", pc_out, 16'h0011);
        chk("bp_rdy4", in_ready, 1);
        tick();
        in_valid = 0;
        chk("bp_pc12", pc_out, 16'h0012);
        chk("bp_v12", out_valid, 1);
        tick();
        chk("bp_empty", out_valid, 0);
        chk("bp_cnt", issue_count, 7);

        // flush with both entries full and an offered word
        out_ready = 0;
        offer(16'h2001, 16'h0020); tick();
        offer(16'h2002, 16'h0021); tick();
        chk("fl_full", in_ready, 0);
        offer(16'h2003, 16'h002C); flush = 1; tick();
        flush = 0; in_valid = 0;
        chk("fl_valid", out_valid, 0);
        chk("fl_rdy", in_ready, 1);
        chk("fl_cnt", issue_count, 7);
        tick();
        chk("fl_no_ghost", out_valid, 0);
        // an issue coinciding with flush still counts
        offer(16'h2004, 16'h0030); tick();
        in_valid = 0; out_ready = 1; flush = 1; tick();
        flush = 0;
        chk("fl_issue_cnt", issue_count, 8);
        chk("fl_issue_valid", out_valid, 0);

        // counter wrap
        offer(16'h3000, 16'h0040); out_ready = 1;
        k = 0;
        while (issue_count != 16'hFFFF && k < 70000) begin
            tick();
            k++;
        end
        chk("wrap_reach", issue_count, 16'hFFFF);
        tick();
        in_valid = 0;
        chk("wrap_zero", issue_count, 0);
        tick();

        // async reset mid-cycle while holding a word
        out_ready = 0;
        offer(16'h53FB, 16'h0055); tick();
        in_valid = 0;
        chk("ar_pre", out_valid, 1);
        #2 reset = 0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_op", instructionOp, 0);
        chk("ar_imm", immediate, 0);
        chk("ar_pc", pc_out, 0);
        chk("ar_cnt", issue_count, 0);
        chk("ar_rdy", in_ready, 1);
        @(negedge clk) reset = 1;
        offer(16'h4A37, 16'h0077); out_ready = 1; tick();
        in_valid = 0;
        chk("post_op", instructionOp, 8'h43);
        chk("post_imm", immediate, 8'h37);
        chk("post_rdest", rdest, 4'hA);
        chk("post_rsrc", rsrc, 4'h7);
        chk("post_pc", pc_out, 16'h0077);
        tick();
        chk("post_cnt", issue_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
